// File: rtl/alu_exec_stage.sv
// Execute-stage slice: ALU-control decode, WIDTH-bit ALU with zero flag, BEQ/BNE gating, 1-cycle registered outputs.
// Optional signed overflow flag enabled by defining ALU_OVERFLOW_EN; otherwise overflow is held at 0.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       alu_function,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             branch_eq,
  input  logic             branch_ne,
  output logic             out_valid,
  output logic [3:0]       alu_operation,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             branch_taken,
  output logic             overflow
);

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_NOR     = 4'b0010;
  localparam logic [3:0] OP_ADD     = 4'b0011;
  localparam logic [3:0] OP_SUB     = 4'b0100;
  localparam logic [3:0] OP_INVALID = 4'b1111;

  localparam logic [2:0] ALUOP_RTYPE  = 3'b111;
  localparam logic [2:0] ALUOP_ADDI   = 3'b100;
  localparam logic [2:0] ALUOP_ORI    = 3'b101;
  localparam logic [2:0] ALUOP_BRANCH = 3'b001;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  logic [3:0]       opNext;
  logic [WIDTH-1:0] resultNext;
  logic             zeroNext;
  logic             branchNext;
  logic             overflowNext;

  // ALU-control decode
  always_comb begin
    opNext = OP_INVALID;
    case (alu_op)
      ALUOP_RTYPE: begin
        case (alu_function)
          FN_ADD:  opNext = OP_ADD;
          FN_SUB:  opNext = OP_SUB;
          FN_AND:  opNext = OP_AND;
          FN_OR:   opNext = OP_OR;
          FN_NOR:  opNext = OP_NOR;
          default: opNext = OP_INVALID;
        endcase
      end
      ALUOP_ADDI:   opNext = OP_ADD;
      ALUOP_ORI:    opNext = OP_OR;
      ALUOP_BRANCH: opNext = OP_SUB;
      default:      opNext = OP_INVALID;
    endcase
  end

  // ALU datapath; INVALID yields 0 so zero reads 1
  always_comb begin
    resultNext = '0;
    case (opNext)
      OP_AND:  resultNext = a & b;
      OP_OR:   resultNext = a | b;
      OP_NOR:  resultNext = ~(a | b);
      OP_ADD:  resultNext = a + b;
      OP_SUB:  resultNext = a - b;
      default: resultNext = '0;
    endcase
  end

  assign zeroNext   = (resultNext == '0);
  assign branchNext = (zeroNext & branch_eq) | (~zeroNext & branch_ne);

`ifdef ALU_OVERFLOW_EN
  always_comb begin
    overflowNext = 1'b0;
    case (opNext)
      OP_ADD:  overflowNext = (a[WIDTH-1] == b[WIDTH-1]) && (resultNext[WIDTH-1] != a[WIDTH-1]);
      OP_SUB:  overflowNext = (a[WIDTH-1] != b[WIDTH-1]) && (resultNext[WIDTH-1] != a[WIDTH-1]);
      default: overflowNext = 1'b0;
    endcase
  end
`else
  assign overflowNext = 1'b0;
`endif

  // Output registers: load on in_valid, otherwise hold (out_valid drops)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      alu_operation <= OP_AND;
      alu_result    <= '0;
      zero          <= 1'b0;
      branch_taken  <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_operation <= opNext;
        alu_result    <= resultNext;
        zero          <= zeroNext;
        branch_taken  <= branchNext;
        overflow      <= overflowNext;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized self-checking bench for alu_exec_stage against an arithmetic reference model.
// Overflow expectations follow ALU_OVERFLOW_EN the same way the design does.
module tb_alu_exec_stage;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [2:0]       alu_op;
  logic [5:0]       alu_function;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             branch_eq;
  logic             branch_ne;
  logic             out_valid;
  logic [3:0]       alu_operation;
  logic [WIDTH-1:0] alu_result;
  logic             zero;
  logic             branch_taken;
  logic             overflow;

  int nCompared;
  int nMismatched;

  logic             expValid;
  logic [3:0]       expOp;
  logic [WIDTH-1:0] expRes;
  logic             expZero;
  logic             expBr;
  logic             expOvf;

  alu_exec_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alu_op(alu_op),
    .alu_function(alu_function), .a(a), .b(b), .branch_eq(branch_eq),
    .branch_ne(branch_ne), .out_valid(out_valid), .alu_operation(alu_operation),
    .alu_result(alu_result), .zero(zero), .branch_taken(branch_taken),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] refOp(input logic [2:0] op, input logic [5:0] fn);
    if (op == 3'b111) begin
      if (fn == 6'h20) return 4'b0011;
      if (fn == 6'h22) return 4'b0100;
      if (fn == 6'h24) return 4'b0000;
      if (fn == 6'h25) return 4'b0001;
      if (fn == 6'h27) return 4'b0010;
      return 4'b1111;
    end
    if (op == 3'b100) return 4'b0011;
    if (op == 3'b101) return 4'b0001;
    if (op == 3'b001) return 4'b0100;
    return 4'b1111;
  endfunction

  function automatic logic [WIDTH-1:0] refResult(input logic [3:0] op, input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    longint unsigned ux = 64'(x);
    longint unsigned uy = 64'(y);
    case (op)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return ~(x | y);
      4'b0011: return WIDTH'((ux + uy) % (64'd1 << WIDTH));
      4'b0100: return WIDTH'((ux + (64'd1 << WIDTH) - uy) % (64'd1 << WIDTH));
      default: return '0;
    endcase
  endfunction

  function automatic logic refOverflow(input logic [3:0] op, input logic [WIDTH-1:0] x,
                                       input logic [WIDTH-1:0] y);
`ifdef ALU_OVERFLOW_EN
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint s;
    longint maxS = (64'sd1 <<< (WIDTH - 1)) - 1;
    longint minS = -(64'sd1 <<< (WIDTH - 1));
    if (op == 4'b0011) s = sx + sy;
    else if (op == 4'b0100) s = sx - sy;
    else return 1'b0;
    return (s > maxS) || (s < minS);
`else
    return 1'b0 & op[0] & x[0] & y[0];
`endif
  endfunction

  task automatic checkAll(input string tag);
    checkVal({tag, ".valid"}, 64'(out_valid), 64'(expValid));
    checkVal({tag, ".op"}, 64'(alu_operation), 64'(expOp));
    checkVal({tag, ".result"}, 64'(alu_result), 64'(expRes));
    checkVal({tag, ".zero"}, 64'(zero), 64'(expZero));
    checkVal({tag, ".branch"}, 64'(branch_taken), 64'(expBr));
    checkVal({tag, ".ovf"}, 64'(overflow), 64'(expOvf));
  endtask

  // Drive one cycle from a negedge, update the model, check at the following negedge
  task automatic step(input string tag, input logic v, input logic [2:0] op, input logic [5:0] fn,
                      input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic be, input logic bn);
    in_valid = v; alu_op = op; alu_function = fn; a = av; b = bv;
    branch_eq = be; branch_ne = bn;
    expValid = v;
    if (v) begin
      expOp   = refOp(op, fn);
      expRes  = refResult(expOp, av, bv);
      expZero = (expRes == '0);
      expBr   = (expZero && be) || (!expZero && bn);
      expOvf  = refOverflow(expOp, av, bv);
    end
    @(negedge clk);
    checkAll(tag);
  endtask

  task automatic clearModel();
    expValid = 1'b0; expOp = 4'b0000; expRes = '0;
    expZero = 1'b0; expBr = 1'b0; expOvf = 1'b0;
  endtask

  logic [2:0] opTable [6];
  logic [5:0] fnTable [6];

  initial begin
    nCompared = 0;
    nMismatched = 0;
    opTable = '{3'b111, 3'b111, 3'b111, 3'b100, 3'b101, 3'b001};
    fnTable = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h3F};
    reset = 1'b0; in_valid = 1'b0; alu_op = '0; alu_function = '0;
    a = '0; b = '0; branch_eq = 1'b0; branch_ne = 1'b0;
    clearModel();
    repeat (3) @(negedge clk);
    checkAll("reset_hold");
    reset = 1'b1;
    step("post_reset_idle", 1'b0, 3'b111, 6'h20, 32'd1, 32'd2, 1'b0, 1'b0);

    step("radd", 1'b1, 3'b111, 6'h20, 32'd5, 32'd7, 1'b0, 1'b0);
    checkVal("radd.const", 64'(alu_result), 64'd12);
    checkVal("radd.opconst", 64'(alu_operation), 64'h3);
    step("rsub_zero", 1'b1, 3'b111, 6'h22, 32'd7, 32'd7, 1'b0, 1'b0);
    checkVal("rsub_zero.const", 64'(zero), 64'd1);
    step("and", 1'b1, 3'b111, 6'h24, 32'hF0F0_0000, 32'h0FF0_00FF, 1'b0, 1'b0);
    checkVal("and.const", 64'(alu_result), 64'h00F0_0000);
    step("or", 1'b1, 3'b111, 6'h25, 32'hF0F0_0000, 32'h0FF0_00FF, 1'b0, 1'b0);
    checkVal("or.const", 64'(alu_result), 64'hFFF0_00FF);
    step("nor", 1'b1, 3'b111, 6'h27, 32'hF0F0_0000, 32'h0FF0_00FF, 1'b0, 1'b0);
    checkVal("nor.const", 64'(alu_result), 64'h000F_FF00);
    step("ori", 1'b1, 3'b101, 6'h00, 32'hF0F0_0000, 32'h0FF0_00FF, 1'b0, 1'b0);
    checkVal("ori.const", 64'(alu_result), 64'hFFF0_00FF);
    step("beq_taken", 1'b1, 3'b001, 6'h00, 32'd9, 32'd9, 1'b1, 1'b0);
    checkVal("beq_taken.const", 64'(branch_taken), 64'd1);
    step("beq_not", 1'b1, 3'b001, 6'h00, 32'd9, 32'd3, 1'b1, 1'b0);
    checkVal("beq_not.const", 64'(branch_taken), 64'd0);
    step("bne_taken", 1'b1, 3'b001, 6'h00, 32'd9, 32'd3, 1'b0, 1'b1);
    checkVal("bne_taken.const", 64'(branch_taken), 64'd1);
    step("both_br", 1'b1, 3'b001, 6'h00, 32'd4, 32'd4, 1'b1, 1'b1);
    step("invalid", 1'b1, 3'b111, 6'h3F, 32'd11, 32'd22, 1'b0, 1'b0);
    checkVal("invalid.const", 64'(alu_operation), 64'hF);
    step("hold", 1'b0, 3'b111, 6'h20, 32'd100, 32'd200, 1'b1, 1'b1);
    step("ovf_add", 1'b1, 3'b111, 6'h20, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    checkVal("ovf_add.result", 64'(alu_result), 64'h8000_0000);
`ifdef ALU_OVERFLOW_EN
    checkVal("ovf_add.const", 64'(overflow), 64'd1);
`else
    checkVal("ovf_add.const", 64'(overflow), 64'd0);
`endif
    step("ovf_sub", 1'b1, 3'b001, 6'h00, 32'h8000_0000, 32'd1, 1'b0, 1'b0);

    // Asynchronous reset between edges clears outputs before the next posedge
    step("pre_async", 1'b1, 3'b100, 6'h00, 32'd40, 32'd2, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    clearModel();
    checkAll("async_reset");
    #1 reset = 1'b1;
    @(negedge clk);
    checkAll("after_async");

    for (int i = 0; i < 400; i++) begin
      logic [2:0] op;
      logic [5:0] fn;
      logic [WIDTH-1:0] av;
      logic [WIDTH-1:0] bv;
      op = ($urandom_range(0, 7) == 0) ? 3'($urandom) : opTable[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fnTable[$urandom_range(0, 5)];
      av = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFF0 + 32'($urandom_range(0, 31)) : 32'($urandom);
      bv = ($urandom_range(0, 3) == 0) ? av : 32'($urandom);
      step("rand", $urandom_range(0, 3) != 0, op, fn, av, bv, 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage datapath slice of the single-cycle MIPS core.
- Combines three pieces: ALU-control decode (ALUOp + funct -> 4-bit operation), the 32-bit ALU with zero flag, and BEQ/BNE branch gating.
- Supports add, addi, sub, ori, or, and, nor, beq, bne.
- Results are registered: one clock of latency, with a valid qualifier.

Parameters:
- WIDTH, 32, datapath width of A, B and result; the Test Plan values assume the default.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands/controls valid this cycle.
- alu_op  input  3  operation class from main control.
- alu_function  input  6  instruction funct field [5:0].
- a  input  WIDTH  operand A (rs data).
- b  input  WIDTH  operand B (rt data or extended immediate, already muxed upstream).
- branch_eq  input  1  BEQ instruction.
- branch_ne  input  1  BNE instruction.
- out_valid  output  1  registered in_valid.
- alu_operation  output  4  registered decoded operation.
- alu_result  output  WIDTH  registered ALU result.
- zero  output  1  registered (result == 0).
- branch_taken  output  1  registered (zero & branch_eq) | (~zero & branch_ne).
- overflow  output  1  signed overflow flag (see Optional Feature).

Behaviour:
- alu_op decode:
  - 3'b111 R-type: use funct.
  - 3'b100 addi: ADD.
  - 3'b101 ori: OR.
  - 3'b001 branch: SUB.
  - Any other alu_op: INVALID.
- R-type funct decode:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR.
  - Any other funct: INVALID.
- Operation codes: AND 4'b0000, OR 4'b0001, NOR 4'b0010, ADD 4'b0011, SUB 4'b0100, INVALID 4'b1111.
- ALU (combinational):
  - AND = a&b; OR = a|b; NOR = ~(a|b).
  - ADD = a+b, modulo 2^WIDTH, carry discarded.
  - SUB = a-b, modulo 2^WIDTH.
  - INVALID: result 0.
- ORI: B is used as supplied; no zero-extension is applied inside this block.
- Combinational zero = (result == 0); for INVALID, zero = 1.
- Branch gating uses the combinational zero of the same operation.
  - branch_eq and branch_ne both 1: branch_taken = 1, since exactly one term is true.
- Register update on posedge clk:
  - in_valid = 1: alu_operation, alu_result, zero, branch_taken and overflow load their combinational values; out_valid = 1.
  - in_valid = 0: out_valid = 0; all other outputs hold their previous values.
- Latency: exactly 1 cycle from inputs to outputs; throughput 1 operation per cycle.
- Reset (reset = 0, asynchronous, immediate):
  - out_valid = 0, alu_operation = 4'b0000, alu_result = 0, zero = 0, branch_taken = 0, overflow = 0.
  - Reset asserted mid-stream discards the in-flight operation.
  - First capture occurs on the first rising edge after reset deasserts.
- No internal state beyond the output registers.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined: overflow = signed two's-complement overflow.
  - ADD: a, b same sign and result sign differs.
  - SUB: a, b differing sign and result sign differs from a.
  - All other operations: 0.
  - Registered with the other outputs.
- Undefined: overflow port still present, driven constant 0. Results are unaffected either way.

Test Plan:
- Reset: hold reset=0, then release; apply no valid input -> all outputs 0, out_valid=0.
- R-type ADD/SUB: alu_op=3'b111.
  - funct=0x20, a=5, b=7 -> next cycle alu_result=12, alu_operation=4'b0011, zero=0.
  - funct=0x22, a=7, b=7 -> alu_result=0, zero=1.
- Logic ops: a=32'hF0F0_0000, b=32'h0FF0_00FF.
  - AND (0x24) -> 32'h00F0_0000.
  - OR (0x25) -> 32'hFFF0_00FF.
  - NOR (0x27) -> 32'h000F_FF00.
  - ori (alu_op=3'b101) -> same as OR.
- Branches: alu_op=3'b001.
  - a=b=9, branch_eq=1 -> branch_taken=1.
  - a=9, b=3, branch_eq=1 -> branch_taken=0.
  - a=9, b=3, branch_ne=1 -> branch_taken=1.
- Invalid/hold:
  - alu_op=3'b111, funct=0x3F -> alu_operation=4'b1111, result 0, zero=1.
  - Then in_valid=0 with new operands -> outputs unchanged, out_valid=0.
- Overflow (ALU_OVERFLOW_EN defined): ADD a=32'h7FFF_FFFF, b=1 -> result 32'h8000_0000, overflow=1. Same stimulus without the macro -> overflow=0.
- Async reset mid-stream: pulse reset=0 between clock edges -> outputs clear immediately, not at the next edge.
